// File: rtl/risc16_pkg.sv
// Shared risc16 pipeline types: fetch-stage states, instruction word type and
// the default boot vector.
package risc16_pkg;

    localparam int INSTR_WIDTH       = 16;
    localparam int DEFAULT_RESET_VEC = 0;

    typedef logic [INSTR_WIDTH-1:0] inst_t;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        LOAD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/dp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered
// (1-cycle) read. Same-address read/write returns the old word.
module dp_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_o <= mem[raddr_i];
    end

endmodule

// File: rtl/fetch_unit.sv
// risc16 instruction-fetch stage: instruction RAM, PC and the BOOT/RUN/LOAD
// controller that lets a loader rewrite the RAM while fetch is halted.
module fetch_unit
    import risc16_pkg::*;
#(
    parameter int INSTR_W   = INSTR_WIDTH,
    parameter int DEPTH     = 256,
    parameter int RESET_VEC = DEFAULT_RESET_VEC,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [ADDR_W-1:0]  redirect_pc_i,
    input  logic               load_req_i,
    input  logic               ld_we_i,
    input  logic [ADDR_W-1:0]  ld_addr_i,
    input  logic [INSTR_W-1:0] ld_data_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  pc_o,
    output logic               valid_o,
    output logic               load_busy_o
);

    localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_VEC);

    fetch_state_t      state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [ADDR_W-1:0] rd_addr;
    logic              ram_we;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_reg <= BOOT;
            pc_reg    <= RESET_ADDR;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

    // pc_reg always names the word the RAM is presenting this cycle, so every
    // PC update is paired with the same value on rd_addr.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        rd_addr    = pc_reg;
        ram_we     = 1'b0;
        unique case (state_reg)
            BOOT: begin
                rd_addr = RESET_ADDR;
                if (load_req_i) begin
                    state_next = LOAD;
                end else begin
                    state_next = RUN;
                    pc_next    = RESET_ADDR;
                end
            end
            RUN: begin
                if (load_req_i) begin
                    state_next = LOAD;
                end else if (redirect_i) begin
                    rd_addr = redirect_pc_i;
                    pc_next = redirect_pc_i;
                end else if (stall_i) begin
                    rd_addr = pc_reg;
                end else begin
                    rd_addr = pc_reg + ADDR_W'(1);
                    pc_next = pc_reg + ADDR_W'(1);
                end
            end
            LOAD: begin
                ram_we = ld_we_i;
                if (!load_req_i) begin
                    state_next = BOOT;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    dp_ram #(
        .DATA_WIDTH (INSTR_W),
        .ADDR_WIDTH (ADDR_W)
    ) u_imem (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .waddr_i (ld_addr_i),
        .wdata_i (ld_data_i),
        .raddr_i (rd_addr),
        .rdata_o (instr_o)
    );

    assign pc_o        = pc_reg;
    assign valid_o     = (state_reg == RUN);
    assign load_busy_o = (state_reg == LOAD);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a reference RAM/PC model pushes expected
// fetch results to a scoreboard queue, popped and checked after each edge.
module tb_fetch_unit;
    import risc16_pkg::*;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              stall = 1'b0;
    logic              redirect = 1'b0;
    logic [ADDR_W-1:0] redirect_pc = '0;
    logic              load_req = 1'b0;
    logic              ld_we = 1'b0;
    logic [ADDR_W-1:0] ld_addr = '0;
    inst_t             ld_data = '0;
    inst_t             instr;
    logic [ADDR_W-1:0] pc;
    logic              valid;
    logic              load_busy;

    fetch_unit #(
        .INSTR_W   (16),
        .DEPTH     (DEPTH),
        .RESET_VEC (0)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .load_req_i    (load_req),
        .ld_we_i       (ld_we),
        .ld_addr_i     (ld_addr),
        .ld_data_i     (ld_data),
        .instr_o       (instr),
        .pc_o          (pc),
        .valid_o       (valid),
        .load_busy_o   (load_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              v;
        logic              b;
        logic [ADDR_W-1:0] pc;
        inst_t             instr;
    } exp_t;

    exp_t              sb[$];
    inst_t             mem_model [DEPTH];
    logic [ADDR_W-1:0] pc_model = '0;
    int                checks = 0;
    int                errors = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Push the expectation for the coming edge, clock it, then pop and compare.
    task automatic cycle(input string tag, input logic v, input logic b);
        exp_t e;
        e.v = v;
        e.b = b;
        e.pc = pc_model;
        e.instr = mem_model[pc_model];
        sb.push_back(e);
        step();
        e = sb.pop_front();
        chk({tag, ".valid"}, {31'd0, valid}, {31'd0, e.v});
        chk({tag, ".busy"}, {31'd0, load_busy}, {31'd0, e.b});
        if (e.v) begin
            chk({tag, ".pc"}, {24'd0, pc}, {24'd0, e.pc});
            chk({tag, ".instr"}, {16'd0, instr}, {16'd0, e.instr});
        end
        $display("t=%0t %s valid=%b busy=%b pc=%0d instr=%h", $time, tag, valid, load_busy, pc, instr);
    endtask

    task automatic run_cycle(input string tag, input logic st, input logic rd, input logic [ADDR_W-1:0] tgt);
        stall = st;
        redirect = rd;
        redirect_pc = tgt;
        if (rd)
            pc_model = tgt;
        else if (!st)
            pc_model = pc_model + 8'd1;
        cycle(tag, 1'b1, 1'b0);
        stall = 1'b0;
        redirect = 1'b0;
    endtask

    task automatic load_write(input logic [ADDR_W-1:0] a, input inst_t d, input logic last);
        ld_we = 1'b1;
        ld_addr = a;
        ld_data = d;
        if (last) load_req = 1'b0;
        mem_model[a] = d;
        cycle("load_wr", 1'b0, !last);
        ld_we = 1'b0;
    endtask

    task automatic boot_to_run(input string tag);
        // stall/redirect must be ignored in BOOT
        stall = 1'b1;
        redirect = 1'b1;
        redirect_pc = 8'd77;
        pc_model = 8'd0;
        cycle(tag, 1'b1, 1'b0);
        stall = 1'b0;
        redirect = 1'b0;
    endtask

    initial begin
        cycle("reset0", 1'b0, 1'b0);
        cycle("reset1", 1'b0, 1'b0);

        // Fill the whole RAM with A000+i through the loader.
        rst_n = 1'b1;
        load_req = 1'b1;
        cycle("enter_load", 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            load_write(ADDR_W'(i), 16'hA000 + 16'(i), i == DEPTH - 1);
        end

        // Reset release timing: BOOT cycle, then first valid fetch.
        rst_n = 1'b0;
        cycle("reset2", 1'b0, 1'b0);
        rst_n = 1'b1;
        chk("boot.valid", {31'd0, valid}, 32'd0);
        boot_to_run("first_fetch");
        for (int i = 0; i < 5; i++) run_cycle("advance", 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) run_cycle("stall", 1'b1, 1'b0, '0);
        run_cycle("after_stall", 1'b0, 1'b0, '0);
        run_cycle("advance7", 1'b0, 1'b0, '0);
        run_cycle("redirect40", 1'b1, 1'b1, 8'd40);
        // Loader strobe in RUN must not write.
        ld_we = 1'b1;
        ld_addr = 8'd42;
        ld_data = 16'hFFFF;
        run_cycle("run_we41", 1'b0, 1'b0, '0);
        run_cycle("run_we42", 1'b0, 1'b0, '0);
        ld_we = 1'b0;
        run_cycle("redirect253", 1'b0, 1'b1, 8'd253);
        for (int i = 0; i < 4; i++) run_cycle("wrap", 1'b0, 1'b0, '0);
        run_cycle("redirect42", 1'b0, 1'b1, 8'd42);

        // Program load from RUN, last write coincides with load_req falling.
        load_req = 1'b1;
        redirect = 1'b1;
        redirect_pc = 8'd99;
        cycle("run_to_load", 1'b0, 1'b1);
        redirect = 1'b0;
        load_write(8'h00, 16'h1234, 1'b0);
        load_write(8'h01, 16'h5678, 1'b1);
        boot_to_run("reload_fetch");
        run_cycle("reload1", 1'b0, 1'b0, '0);
        run_cycle("reload2", 1'b0, 1'b0, '0);

        // Reset in the middle of LOAD; RAM must survive.
        load_req = 1'b1;
        cycle("enter_load2", 1'b0, 1'b1);
        load_write(8'h03, 16'hBEEF, 1'b0);
        rst_n = 1'b0;
        cycle("reset_mid_load", 1'b0, 1'b0);
        rst_n = 1'b1;
        load_req = 1'b0;
        boot_to_run("post_reset");
        run_cycle("redirect3", 1'b0, 1'b1, 8'd3);
        run_cycle("after3", 1'b0, 1'b0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
